// File: rtl/proc_seq_pkg.sv
// Shared opcodes, bubble word and state type
// for the program sequencer.
package proc_seq_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  // mv R0,R0: harmless filler for idle T0 slots
  localparam logic [8:0] BUBBLE = 9'b000000000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } seq_state_t;

  function automatic logic [2:0] op_of(
    input logic [8:0] w
  );
    return w[8:6];
  endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// Program memory bus: address, read strobe and
// read data returned one cycle after MemRd.
interface proc_sequencer_if #(
  parameter int ADDR_W = 6
);

  logic [ADDR_W-1:0] MemAddr;
  logic              MemRd;
  logic [8:0]        MemData;

  modport master (
    output MemAddr,
    output MemRd,
    input  MemData
  );

  modport slave (
    input  MemAddr,
    input  MemRd,
    output MemData
  );

endinterface

// File: rtl/proc_sequencer_prefetch_fifo.sv
// Two-entry 9-bit prefetch buffer (seq_prefetch_fifo).
// Ports: clk, rst_n, flush, push/wdata, pop; head, next, count.
module seq_prefetch_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic [8:0] wdata,
  input  logic       pop,
  output logic [8:0] head,
  output logic [8:0] next,
  output logic [1:0] count
);

  logic [8:0] e0;
  logic [8:0] e1;
  logic [1:0] cnt;
  logic       do_pop;
  logic       do_push;

  assign do_pop  = pop && (cnt != 2'd0);
  // a full buffer still accepts a word if it pops
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= wdata;
          else             e1 <= wdata;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= wdata;
          end else begin
            e0 <= e1;
            e1 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = e0;
  assign next  = e1;
  assign count = cnt;

endmodule

// File: rtl/proc_sequencer.sv
// Feeds program words to a processor DIN port at T0/IMM slots.
// Ports: Clock, Resetn, Start, Done, mem (bus master), DIN, Run,
// Busy, Halted, InstrCount; Step only with SEQ_STEP_EN defined.
module proc_sequencer
  import proc_seq_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic             Done,
`ifdef SEQ_STEP_EN
  input  logic             Step,
`endif
  proc_sequencer_if.master mem,
  output logic [8:0]       DIN,
  output logic             Run,
  output logic             Busy,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [ADDR_W-1:0] PC_ONE  = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE = 1;

  seq_state_t        state;
  seq_state_t        state_nx;
  logic [ADDR_W-1:0] pc;
  logic              rd_pend;
  logic              t0;
  logic              imm;
  logic [8:0]        din_q;
  logic [CNT_W-1:0]  cnt;

  logic [8:0] head;
  logic [8:0] second;
  logic [1:0] occ;
  logic [2:0] fill;
  logic       pop;
  logic       restart;
  logic       is_run;
  logic       head_halt;
  logic       halt_buf;
  logic       can_issue;
  logic       step_ok;
  logic       issue;
  logic       issue_mvi;
  logic       rd;

  seq_prefetch_fifo u_fifo (
    .clk   (Clock),
    .rst_n (Resetn),
    .flush (restart),
    .push  (rd_pend),
    .wdata (mem.MemData),
    .pop   (pop),
    .head  (head),
    .next  (second),
    .count (occ)
  );

  assign is_run = (state == RUN);
  assign fill   = {1'b0, occ} + {2'b00, rd_pend};

  // in an IMM slot the head is the immediate, not an opcode
  assign head_halt = (occ != 2'd0) && !imm
                  && (op_of(head) == OP_HALT);
  assign halt_buf  =
      ((occ != 2'd0) && (op_of(head) == OP_HALT))
   || ((occ == 2'd2) && (op_of(second) == OP_HALT));

  // mvi needs its immediate already buffered
  assign can_issue = (op_of(head) == OP_MVI)
                   ? (occ == 2'd2)
                   : (occ != 2'd0);

  assign issue = is_run && t0 && !imm && !head_halt
              && can_issue && step_ok;
  assign issue_mvi = issue && (op_of(head) == OP_MVI);
  assign pop = issue || (imm && (occ != 2'd0));

  assign rd = is_run && !halt_buf && (fill < 3'd2);

`ifdef SEQ_STEP_EN
  logic step_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) step_q <= 1'b0;
    else         step_q <= (step_q && !issue) || Step;
  end

  assign step_ok = step_q;
`else
  assign step_ok = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) state_nx = RUN;
      end
      RUN: begin
        if (head_halt) state_nx = HALTED;
      end
      HALTED: begin
        if (Start) begin
          state_nx = RUN;
          restart  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    DIN = din_q;
    Run = 1'b0;
    if (imm) begin
      DIN = head;
    end else if (t0) begin
      DIN = issue ? head : BUBBLE;
      Run = issue;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      pc      <= '0;
      rd_pend <= 1'b0;
      t0      <= 1'b1;
      imm     <= 1'b0;
      din_q   <= BUBBLE;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      rd_pend <= rd;
      t0      <= Done;
      imm     <= issue_mvi;
      din_q   <= DIN;
      if (restart)  pc <= '0;
      else if (rd)  pc <= pc + PC_ONE;
      if (restart)  cnt <= '0;
      else if (Run && (cnt != '1))
        cnt <= cnt + CNT_ONE;
    end
  end

  assign mem.MemAddr = pc;
  assign mem.MemRd   = rd;
  assign Busy        = is_run;
  assign Halted      = (state == HALTED);
  assign InstrCount  = cnt;

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench for proc_sequencer: a processor/Done model
// and memory model; issued words checked in program order.
`timescale 1ns/1ps
module tb_proc_sequencer;
  import proc_seq_pkg::*;

  typedef struct packed {
    logic [8:0] w;
    logic       imm;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       done  = 1'b0;
`ifdef SEQ_STEP_EN
  logic       step  = 1'b0;
  bit         step_auto = 1'b1;
  bit         step_req  = 1'b0;
`endif
  logic [8:0] din;
  logic       run;
  logic       busy;
  logic       halted;
  logic [7:0] icount;

  proc_sequencer_if #(.ADDR_W(6)) mem_if ();

  proc_sequencer #(.ADDR_W(6), .CNT_W(8)) dut (
    .Clock      (clk),
    .Resetn     (rst_n),
    .Start      (start),
    .Done       (done),
`ifdef SEQ_STEP_EN
    .Step       (step),
`endif
    .mem        (mem_if),
    .DIN        (din),
    .Run        (run),
    .Busy       (busy),
    .Halted     (halted),
    .InstrCount (icount)
  );

  always #5 clk = ~clk;

  logic [8:0] prog [64];
  exp_t       q [$];

  int checks = 0;
  int fails  = 0;

  bit         t0_cur    = 1'b1;
  bit         imm_cur   = 1'b0;
  int         since     = 0;
  int         dly       = 1;
  int         d_min     = 1;
  int         d_max     = 3;
  logic [8:0] din_prev  = '0;
  int         exp_addr  = 0;
  int         reads     = 0;
  int         consumed  = 0;
  int         model_cnt = 0;
  int         runs_seen = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // memory: data for a read appears in the next cycle,
  // otherwise random junk on the bus
  initial begin
    bit         rd_prev;
    logic [5:0] a_prev;
    mem_if.MemData = '0;
    forever begin
      @(negedge clk);
      rd_prev = mem_if.MemRd;
      a_prev  = mem_if.MemAddr;
      @(posedge clk);
      #1;
      mem_if.MemData = rd_prev ? prog[a_prev]
                               : 9'($urandom);
    end
  end

`ifdef SEQ_STEP_EN
  initial forever begin
    @(posedge clk);
    #2;
    if (step_auto) step = ($urandom_range(3, 0) == 0);
    else           step = step_req;
    step_req = 1'b0;
  end
`endif

  // monitor + processor model (drives Done)
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      t0_cur   = 1'b1;
      imm_cur  = 1'b0;
      done     = 1'b0;
      since    = 0;
      din_prev = '0;
    end else begin
      bit   nxt_imm;
      exp_t e;
      nxt_imm = 1'b0;
      if (mem_if.MemRd) begin
        chk("mem_addr", 32'(mem_if.MemAddr),
            32'(exp_addr));
        exp_addr = (exp_addr + 1) % 64;
        reads++;
        chk("prefetch_depth",
            32'((reads - consumed) <= 2), 1);
      end
      if (imm_cur) begin
        chk("imm_avail", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("imm_kind", 32'(e.imm), 1);
          chk("imm_din", 32'(din), 32'(e.w));
          consumed++;
        end
        chk("imm_run", 32'(run), 0);
      end else if (t0_cur) begin
        if (run) begin
          runs_seen++;
          chk("issue_avail", 32'(q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("issue_kind", 32'(e.imm), 0);
            chk("issue_din", 32'(din), 32'(e.w));
            consumed++;
            model_cnt++;
            nxt_imm = (e.w[8:6] == OP_MVI);
          end
        end else begin
          chk("bubble_din", 32'(din), 0);
        end
      end else begin
        chk("hold_run", 32'(run), 0);
        chk("hold_din", 32'(din), 32'(din_prev));
      end
      din_prev = din;
      if (t0_cur) begin
        since = 0;
        dly   = $urandom_range(d_max, d_min);
      end else begin
        since++;
      end
      done    = (since == dly);
      t0_cur  = done;
      imm_cur = nxt_imm;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    q.delete();
    exp_addr  = 0;
    reads     = 0;
    consumed  = 0;
    model_cnt = 0;
  endtask

  // expected issue order: walk the program up to halt
  task automatic load_expect();
    int   a;
    exp_t e;
    a = 0;
    for (int n = 0; n < 64; n++) begin
      logic [8:0] w;
      w = prog[a];
      if (w[8:6] == OP_HALT) break;
      e.w   = w;
      e.imm = 1'b0;
      q.push_back(e);
      if (w[8:6] == OP_MVI) begin
        a     = (a + 1) % 64;
        e.w   = prog[a];
        e.imm = 1'b1;
        q.push_back(e);
      end
      a = (a + 1) % 64;
    end
  endtask

  task automatic gen_random(input int len);
    int i;
    for (int k = 0; k < 64; k++) prog[k] = 9'($urandom);
    i = 0;
    while (i < len) begin
      logic [2:0] op;
      op = 3'($urandom_range(3, 0));
      prog[i] = {op, 6'($urandom)};
      i++;
      if (op == OP_MVI) begin
        prog[i] = 9'($urandom_range(447, 0));
        i++;
      end
    end
    prog[i] = {OP_HALT, 6'($urandom)};
  endtask

  task automatic pulse_start(input bit fresh);
    start = 1'b1;
    if (fresh) begin
      clear_model();
      load_expect();
    end
    tick();
    start = 1'b0;
  endtask

  task automatic run_prog(input string tag,
                          input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_halted"}, 32'(halted), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_drained"}, 32'(q.size()), 0);
    chk({tag, "_icount"}, 32'(icount),
        32'((model_cnt > 255) ? 255 : model_cnt));
  endtask

  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_din"}, 32'(din), 0);
    chk({tag, "_run"}, 32'(run), 0);
    chk({tag, "_memrd"}, 32'(mem_if.MemRd), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_halted"}, 32'(halted), 0);
    chk({tag, "_icount"}, 32'(icount), 0);
    tick();
    tick();
    clear_model();
    rst_n = 1'b1;
  endtask

  initial begin
    int rd_cnt;
    int n;
    for (int k = 0; k < 64; k++) prog[k] = '0;
    tick();
    reset_now("reset");

    // idle: bubbles only, no reads
    d_min  = 1;
    d_max  = 1;
    rd_cnt = 0;
    repeat (20) begin
      tick();
      if (mem_if.MemRd) rd_cnt++;
    end
    chk("idle_memrd", 32'(rd_cnt), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_halted", 32'(halted), 0);

    // mvi, immediate, mv, halt
    for (int k = 0; k < 64; k++) prog[k] = '0;
    prog[0] = 9'b001000000;
    prog[1] = 9'b000000101;
    prog[2] = 9'b000001000;
    prog[3] = 9'b111000000;
    d_min = 1;
    d_max = 3;
    pulse_start(1'b1);
    run_prog("mvi_prog", 400);
    chk("mvi_prog_count", 32'(icount), 2);

`ifdef SEQ_STEP_EN
    // single Step releases exactly one instruction
    step_auto = 1'b0;
    pulse_start(1'b1);
    n = runs_seen;
    repeat (30) tick();
    chk("step_none", 32'(runs_seen - n), 0);
    step_req = 1'b1;
    repeat (30) tick();
    chk("step_one", 32'(runs_seen - n), 1);
    step_auto = 1'b1;
    run_prog("step_prog", 400);
`endif

    // one add then halt, slow Done
    prog[0] = 9'b010000001;
    prog[1] = 9'b111000000;
    d_min = 3;
    d_max = 3;
    n = runs_seen;
    pulse_start(1'b1);
    run_prog("slow_done", 400);
    chk("slow_done_runs", 32'(runs_seen - n), 1);

    // random programs, restarted from HALTED
    for (int t = 0; t < 8; t++) begin
      d_min = 1;
      d_max = $urandom_range(4, 1);
      gen_random($urandom_range(30, 2));
      pulse_start(1'b1);
      if (t == 3) begin
        repeat (6) tick();
        if (busy) pulse_start(1'b0);
      end
      run_prog("rand_prog", 2000);
    end

    // reset during an IMM slot
    gen_random(30);
    prog[0] = {OP_MVI, 6'd3};
    prog[1] = 9'd77;
    d_min = 1;
    d_max = 2;
    pulse_start(1'b1);
    n = 0;
    while (!imm_cur && n < 200) begin
      tick();
      n++;
    end
    chk("imm_slot_seen", 32'(imm_cur), 1);
    #1;
    reset_now("imm_reset");
    repeat (6) tick();
    chk("post_reset_busy", 32'(busy), 0);
    pulse_start(1'b1);
    run_prog("post_reset", 2000);

    // zero program: address wrap, counter saturation
    for (int k = 0; k < 64; k++) prog[k] = '0;
    d_min = 1;
    d_max = 1;
    pulse_start(1'b1);
    q.delete();
    for (int k = 0; k < 400; k++) q.push_back('0);
    n = 0;
    while (model_cnt < 300 && n < 6000) begin
      tick();
      n++;
    end
    chk("sat_reached", 32'(model_cnt >= 300), 1);
    chk("sat_icount", 32'(icount), 255);
    chk("addr_wrapped", 32'(reads > 64), 1);
    chk("sat_busy", 32'(busy), 1);
    reset_now("final_reset");
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
